// File: rtl/dm_responder.sv
// Single-port word memory slave: latches a request, waits WAIT cycles, then
// answers with a one-cycle ack carrying read data or an error flag.
module dm_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        commit;
    logic        take;
    logic        err_q;

    logic [31:0] addr_q;
    logic        wr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [31:0] t_addr;
    logic        t_wr;
    logic [31:0] t_wdata;
    logic [3:0]  t_be;
    logic [AW-1:0] idx;
    logic        bad;

    logic [31:0] mem [DEPTH];

    assign take = (state == S_IDLE) && req;

    // With WAIT=0 the commit happens on the accepting edge, so use live inputs in IDLE
    assign t_addr  = (state == S_IDLE) ? addr  : addr_q;
    assign t_wr    = (state == S_IDLE) ? wr    : wr_q;
    assign t_wdata = (state == S_IDLE) ? wdata : wdata_q;
    assign t_be    = (state == S_IDLE) ? be    : be_q;

    assign idx = t_addr[AW+1:2];
    assign bad = (t_addr[1:0] != 2'b00) || (t_addr[31:AW+2] != '0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 4'(WAIT - 1);
                    end else begin
                        state_nxt = S_RESP;
                        commit    = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            err_q <= 1'b0;
            rdata <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err_q <= commit && bad;
            if (commit && !bad) begin
                if (t_wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (t_be[b]) mem[idx][8*b +: 8] <= t_wdata[8*b +: 8];
                    end
                end else begin
                    rdata <= mem[idx];
                end
            end
        end
    end

    // Request fields are only consumed after a take, so they need no reset
    always_ff @(posedge clk) begin
        if (take) begin
            addr_q  <= addr;
            wr_q    <= wr;
            wdata_q <= wdata;
            be_q    <= be;
        end
    end

    assign ack = (state == S_RESP);
    assign err = err_q && ack;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: WAIT=2 instance for most scenarios,
// WAIT=0 instance for back-to-back throughput.
module tb_dm_responder;

    logic        clk;
    logic        reset;

    logic        req1, wr1, ack1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  be1;

    logic        req0, wr0, ack0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  be0;

    int nvec;
    int nfail;

    dm_responder #(.DEPTH(64), .WAIT(2)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .wr(wr1), .addr(addr1),
        .wdata(wdata1), .be(be1), .ack(ack1), .rdata(rdata1), .err(err1)
    );

    dm_responder #(.DEPTH(64), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .wr(wr0), .addr(addr0),
        .wdata(wdata0), .be(be0), .ack(ack0), .rdata(rdata0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction on the WAIT=2 instance; lat counts edges from the sampling edge to ack
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output int lat, output logic e,
                       output logic [31:0] rd, output logic ack_after);
        req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; be1 = b;
        @(posedge clk); #1;
        req1 = 1'b0;
        lat = 1;
        while (ack1 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e  = err1;
        rd = rdata1;
        @(posedge clk); #1;
        ack_after = ack1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0; be1 = 0;
        req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0; be0 = 0;
        #3;
        nvec++; if (ack1 !== 1'b0) begin nfail++; $display("FAIL reset_ack1 got %b want 0", ack1); end
        nvec++; if (err1 !== 1'b0) begin nfail++; $display("FAIL reset_err1 got %b want 0", err1); end
        nvec++; if (rdata1 !== 32'h0) begin nfail++; $display("FAIL reset_rdata1 got %h want 0", rdata1); end
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (ack0 !== 1'b0) begin nfail++; $display("FAIL reset_ack0 got %b want 0", ack0); end
        nvec++; if (rdata0 !== 32'h0) begin nfail++; $display("FAIL reset_rdata0 got %h want 0", rdata0); end
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; logic e, aa; logic [31:0] rd;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, e, rd, aa);
        nvec++; if (lat !== 3) begin nfail++; $display("FAIL wr_latency got %0d want 3", lat); end
        nvec++; if (e !== 1'b0) begin nfail++; $display("FAIL wr_err got %b want 0", e); end
        nvec++; if (aa !== 1'b0) begin nfail++; $display("FAIL wr_ack_width got %b want 0", aa); end
        txn(1'b0, 32'h10, 32'h0, 4'h0, lat, e, rd, aa);
        nvec++; if (lat !== 3) begin nfail++; $display("FAIL rd_latency got %0d want 3", lat); end
        nvec++; if (rd !== 32'hDEADBEEF) begin nfail++; $display("FAIL rd_data got %h want deadbeef", rd); end
        nvec++; if (e !== 1'b0) begin nfail++; $display("FAIL rd_err got %b want 0", e); end
        nvec++; if (aa !== 1'b0) begin nfail++; $display("FAIL rd_ack_width got %b want 0", aa); end
    endtask

    task automatic test_byte_enable();
        int lat; logic e, aa; logic [31:0] rd;
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, lat, e, rd, aa);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, e, rd, aa);
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, lat, e, rd, aa);
        nvec++; if (lat !== 3 || e !== 1'b0) begin nfail++; $display("FAIL be0_ack got lat=%0d err=%b want lat=3 err=0", lat, e); end
        txn(1'b0, 32'h20, 32'h0, 4'h0, lat, e, rd, aa);
        nvec++; if (rd !== 32'h11BB33DD) begin nfail++; $display("FAIL be_merge got %h want 11bb33dd", rd); end
    endtask

    task automatic test_errors();
        int lat; logic e, aa; logic [31:0] rd;
        txn(1'b0, 32'h06, 32'h0, 4'h0, lat, e, rd, aa);
        nvec++; if (lat !== 3 || e !== 1'b1) begin nfail++; $display("FAIL misalign_rd got lat=%0d err=%b want lat=3 err=1", lat, e); end
        nvec++; if (rd !== 32'h11BB33DD) begin nfail++; $display("FAIL misalign_rdata got %h want 11bb33dd", rd); end
        nvec++; if (aa !== 1'b0 || err1 !== 1'b0) begin nfail++; $display("FAIL err_after_ack got ack=%b err=%b want 0 0", aa, err1); end
        txn(1'b0, 32'h100, 32'h0, 4'h0, lat, e, rd, aa);
        nvec++; if (lat !== 3 || e !== 1'b1) begin nfail++; $display("FAIL oor_rd got lat=%0d err=%b want lat=3 err=1", lat, e); end
        nvec++; if (rd !== 32'h11BB33DD) begin nfail++; $display("FAIL oor_rdata got %h want 11bb33dd", rd); end
        txn(1'b1, 32'h100, 32'h0BAD0BAD, 4'hF, lat, e, rd, aa);
        nvec++; if (e !== 1'b1) begin nfail++; $display("FAIL oor_wr_err got %b want 1", e); end
        txn(1'b1, 32'h12, 32'h0BAD0BAD, 4'hF, lat, e, rd, aa);
        nvec++; if (e !== 1'b1) begin nfail++; $display("FAIL misalign_wr_err got %b want 1", e); end
        txn(1'b0, 32'h00, 32'h0, 4'h0, lat, e, rd, aa);
        nvec++; if (rd !== 32'h0 || e !== 1'b0) begin nfail++; $display("FAIL no_wrap got %h err=%b want 00000000 err=0", rd, e); end
        txn(1'b0, 32'h10, 32'h0, 4'h0, lat, e, rd, aa);
        nvec++; if (rd !== 32'hDEADBEEF) begin nfail++; $display("FAIL misalign_nowrite got %h want deadbeef", rd); end
        txn(1'b1, 32'hFC, 32'h5A5A5A5A, 4'hF, lat, e, rd, aa);
        nvec++; if (e !== 1'b0) begin nfail++; $display("FAIL last_word_wr_err got %b want 0", e); end
        txn(1'b0, 32'hFC, 32'h0, 4'h0, lat, e, rd, aa);
        nvec++; if (rd !== 32'h5A5A5A5A || e !== 1'b0) begin nfail++; $display("FAIL last_word_rd got %h err=%b want 5a5a5a5a err=0", rd, e); end
    endtask

    task automatic test_back_to_back();
        int k;
        k = 0;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0; wdata0 = 32'hC0DE0000; be0 = 4'hF;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            nvec++;
            if (ack0 !== ((c % 2) == 0)) begin
                nfail++; $display("FAIL b2b_ack cycle %0d got %b want %b", c, ack0, (c % 2) == 0);
            end
            if ((c % 2) == 0) begin
                if (k >= 4) begin
                    nvec++;
                    if (rdata0 !== 32'hC0DE0000 + 32'(k - 4) || err0 !== 1'b0) begin
                        nfail++; $display("FAIL b2b_rdata %0d got %h err=%b want %h err=0", k, rdata0, err0, 32'hC0DE0000 + 32'(k - 4));
                    end
                end
                k++;
                if (k < 8) begin
                    wr0 = (k < 4); addr0 = 32'((k % 4) * 4); wdata0 = 32'hC0DE0000 + 32'(k);
                end
            end
        end
        req0 = 1'b0;
    endtask

    task automatic test_reset_abort();
        int lat; logic e, aa; logic [31:0] rd;
        txn(1'b1, 32'h08, 32'h12345678, 4'hF, lat, e, rd, aa);
        txn(1'b0, 32'h08, 32'h0, 4'h0, lat, e, rd, aa);
        nvec++; if (rd !== 32'h12345678) begin nfail++; $display("FAIL pre_abort_rd got %h want 12345678", rd); end
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h08; wdata1 = 32'hFFFFFFFF; be1 = 4'hF;
        @(posedge clk); #1;
        req1 = 1'b0;
        reset = 1'b0;
        #2;
        nvec++; if (ack1 !== 1'b0 || err1 !== 1'b0 || rdata1 !== 32'h0) begin
            nfail++; $display("FAIL abort_outputs got ack=%b err=%b rdata=%h want 0 0 0", ack1, err1, rdata1);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            nvec++; if (ack1 !== 1'b0) begin nfail++; $display("FAIL abort_no_ack cycle %0d got %b want 0", c, ack1); end
        end
        // Reset held across the edge that would have committed the write
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0C; wdata1 = 32'h55555555; be1 = 4'hF;
        @(posedge clk); #1;
        req1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        nvec++; if (ack1 !== 1'b0) begin nfail++; $display("FAIL commit_abort_ack got %b want 0", ack1); end
        reset = 1'b1;
        txn(1'b0, 32'h08, 32'h0, 4'h0, lat, e, rd, aa);
        nvec++; if (lat !== 3 || rd !== 32'h0) begin nfail++; $display("FAIL post_reset_rd got lat=%0d rdata=%h want lat=3 00000000", lat, rd); end
        txn(1'b0, 32'h0C, 32'h0, 4'h0, lat, e, rd, aa);
        nvec++; if (rd !== 32'h0) begin nfail++; $display("FAIL commit_abort_mem got %h want 00000000", rd); end
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        test_reset();
        @(posedge clk); #1;
        test_write_read();
        test_byte_enable();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, the number of 32-bit words stored (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT, default 2, the number of wait cycles inserted before a response (0..15).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 req  input  1  initiator request; held with addr/wr/wdata/be stable until ack.
REQ-007 wr  input  1  1 = write, 0 = read.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  write data.
REQ-010 be  input  4  byte enables for writes; be[i] selects wdata[8i+7:8i].
REQ-011 ack  output  1  single-cycle response strobe.
REQ-012 rdata  output  32  read data, valid when ack=1 and wr was 0.
REQ-013 err  output  1  error flag, valid only when ack=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; after reset the state SHALL be IDLE.
REQ-015 In IDLE with req=1 at a rising edge, SHALL latch addr, wr, wdata and be; it SHALL enter WAIT with counter=WAIT-1 if WAIT>0, else enter RESP.
REQ-016 In WAIT, SHALL decrement the counter each cycle and enter RESP on the edge where the counter is 0.
REQ-017 The edge that enters RESP SHALL commit the write, or register the read word into rdata.
REQ-018 ack SHALL be 1 exactly while in RESP (one cycle): request sampled at edge N gives ack high in cycle N+WAIT+1.
REQ-019 RESP SHALL always return to IDLE on the next edge; req=1 sampled in that next cycle SHALL start a new transaction (back-to-back period WAIT+2 cycles).
REQ-020 req, addr, wr, wdata and be SHALL be ignored outside IDLE; a req drop mid-transaction SHALL NOT abort it.
REQ-021 Word index SHALL be addr[log2(DEPTH)+1:2].
REQ-022 addr[1:0]!=0 (misaligned) SHALL give err=1 with ack; no write; rdata unchanged.
REQ-023 addr >= 4*DEPTH (out of range) SHALL give err=1 with ack; no write; rdata unchanged; the index SHALL NOT wrap.
REQ-024 A write SHALL update only the bytes with be set; be=0000 SHALL complete with ack, err=0 and no change.
REQ-025 For reads, be SHALL be ignored and the full word returned.
REQ-026 rdata SHALL hold its last value until the next successful read response.
REQ-027 err SHALL be 0 whenever ack=0.

Reset
REQ-028 With reset=0, SHALL immediately force: state IDLE, ack=0, err=0, rdata=0, counter=0, all memory words=0.
REQ-029 Reset mid-transaction SHALL abort it with no ack and no memory update, including reset asserted in the cycle the write would commit.
REQ-030 The first rising edge after reset deasserts SHALL be able to accept a request.

Verification
REQ-031 WAIT=2: write addr=0x10, wdata=0xDEADBEEF, be=1111 at edge N -> ack in cycle N+3, err=0; then read 0x10 -> rdata=0xDEADBEEF, ack after 3 cycles.
REQ-032 Write 0x11223344 to addr 0x20 (be=1111), then write 0xAABBCCDD with be=0101 -> read returns 0x11BB33DD.
REQ-033 Read addr=0x06 (misaligned), then read addr=0x100 with DEPTH=64 -> both ack with err=1, rdata unchanged, memory unchanged.
REQ-034 WAIT=0, req held high for 4 back-to-back reads -> ack on every second cycle, each ack exactly one cycle wide.
REQ-035 Write 0x12345678 to addr 0x08 and complete it; start a second write to 0x08 and pulse reset low during WAIT -> no ack, outputs 0; read 0x08 after reset returns 0x00000000.
